// File: rtl/md_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : md_sequencer
//  Description : Control FSM for the shared multicycle multiply/divide
//                datapath: latches operands, sequences start/enable/step and
//                pulses data_resultRDY with data_exception on completion.
//                Optional build macro MD_SEQ_ZERO_FASTPATH_EN retires a
//                divide-by-zero straight to DONE without running the datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_sequencer #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 33,
    parameter int CNT_W       = 6
) (
    input  logic             clock,
    input  logic             ctrl_reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] dp_operandA,
    output logic [WIDTH-1:0] dp_operandB,
    output logic             dp_op,
    output logic             dp_start,
    output logic             dp_enable,
    output logic [CNT_W-1:0] dp_step,
    input  logic             dp_overflow,
    output logic             data_resultRDY,
    output logic             data_exception,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_MULT_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

    state_t r_state;
    logic   w_accept;
    logic   w_accept_div;
    logic   w_last;

    // Multiply wins a tie, so a divide is only taken when MULT is low.
    assign w_accept     = ctrl_MULT | ctrl_DIV;
    assign w_accept_div = ctrl_DIV & ~ctrl_MULT;
    assign w_last       = (dp_step == (dp_op ? c_DIV_LAST : c_MULT_LAST));

`ifdef MD_SEQ_ZERO_FASTPATH_EN
    logic w_zero_div;
    assign w_zero_div = w_accept_div & (data_operandB == '0);
`endif

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_state        <= S_IDLE;
            dp_operandA    <= '0;
            dp_operandB    <= '0;
            dp_op          <= 1'b0;
            dp_start       <= 1'b0;
            dp_enable      <= 1'b0;
            dp_step        <= '0;
            data_resultRDY <= 1'b0;
            data_exception <= 1'b0;
            busy           <= 1'b0;
        end else begin
            dp_start       <= 1'b0;
            data_resultRDY <= 1'b0;
            data_exception <= 1'b0;

            if (w_accept) begin
                // A new request pre-empts whatever is in flight.
                dp_operandA <= data_operandA;
                dp_operandB <= data_operandB;
                dp_op       <= w_accept_div;
                dp_step     <= '0;
                busy        <= 1'b1;
`ifdef MD_SEQ_ZERO_FASTPATH_EN
                if (w_zero_div) begin
                    r_state        <= S_DONE;
                    dp_enable      <= 1'b0;
                    data_resultRDY <= 1'b1;
                    data_exception <= 1'b1;
                end else begin
                    r_state   <= S_RUN;
                    dp_start  <= 1'b1;
                    dp_enable <= 1'b1;
                end
`else
                r_state   <= S_RUN;
                dp_start  <= 1'b1;
                dp_enable <= 1'b1;
`endif
            end else begin
                case (r_state)
                    S_RUN: begin
                        if (w_last) begin
                            r_state        <= S_DONE;
                            dp_enable      <= 1'b0;
                            data_resultRDY <= 1'b1;
                            data_exception <= dp_op ? (dp_operandB == '0) : dp_overflow;
                        end else begin
                            dp_step <= dp_step + CNT_W'(1);
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        dp_step <= '0;
                        busy    <= 1'b0;
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        dp_enable <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_md_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md_sequencer
//  Description : Scoreboard bench for md_sequencer with directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_md_sequencer;

    logic        clock = 1'b0;
    logic        ctrl_reset_n = 1'b1;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] dp_operandA;
    logic [31:0] dp_operandB;
    logic        dp_op;
    logic        dp_start;
    logic        dp_enable;
    logic [5:0]  dp_step;
    logic        dp_overflow = 1'b0;
    logic        data_resultRDY;
    logic        data_exception;
    logic        busy;

    md_sequencer #(
        .WIDTH(32), .MULT_CYCLES(32), .DIV_CYCLES(33), .CNT_W(6)
    ) dut (
        .clock(clock), .ctrl_reset_n(ctrl_reset_n),
        .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .dp_operandA(dp_operandA), .dp_operandB(dp_operandB),
        .dp_op(dp_op), .dp_start(dp_start), .dp_enable(dp_enable),
        .dp_step(dp_step), .dp_overflow(dp_overflow),
        .data_resultRDY(data_resultRDY), .data_exception(data_exception),
        .busy(busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int   due;
        logic exc;
        logic op;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drives a one-cycle request and, if a completion is due, queues it.
    task automatic issue(input logic m, input logic d, input logic [31:0] a,
                         input logic [31:0] b, input bit expect_rdy, input logic exc);
        exp_t e;
        int   n;
        @(negedge clock);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        if (expect_rdy) begin
            e.op  = ~m & d;
            n     = e.op ? 33 : 32;
            e.due = cyc + 1 + n;
`ifdef MD_SEQ_ZERO_FASTPATH_EN
            if (e.op && b == 32'd0) e.due = cyc + 1;
`endif
            e.exc = exc;
            sb.push_back(e);
        end
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int k = 0;
        while (busy && k < limit) begin
            @(negedge clock);
            k++;
        end
        check(name, longint'(busy), 0);
    endtask

    // Monitor: every completion pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        if (ctrl_reset_n) begin
            if (data_resultRDY) begin
                if (sb.size() == 0) begin
                    check("unexpected_rdy", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rdy_cycle", cyc, e.due);
                    check("rdy_exception", longint'(data_exception), longint'(e.exc));
                    check("rdy_op", longint'(dp_op), longint'(e.op));
                end
            end else begin
                check("exception_without_rdy", longint'(data_exception), 0);
            end
        end
    end

    initial begin
        int bad;
        int en_cnt;

        #1 ctrl_reset_n = 1'b0;
        @(negedge clock);
        check("rst_busy", longint'(busy), 0);
        check("rst_step", longint'(dp_step), 0);
        check("rst_enable", longint'(dp_enable), 0);
        check("rst_start", longint'(dp_start), 0);
        check("rst_rdy", longint'(data_resultRDY), 0);
        check("rst_op", longint'(dp_op), 0);
        check("rst_opA", longint'(dp_operandA), 0);
        check("rst_opB", longint'(dp_operandB), 0);
        ctrl_reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Multiply 7 x 6
        issue(1, 0, 32'd7, 32'd6, 1, 0);
        check("mul_start", longint'(dp_start), 1);
        check("mul_enable", longint'(dp_enable), 1);
        check("mul_step0", longint'(dp_step), 0);
        check("mul_opA", longint'(dp_operandA), 7);
        check("mul_opB", longint'(dp_operandB), 6);
        check("mul_op", longint'(dp_op), 0);
        bad = 0;
        for (int i = 1; i < 32; i++) begin
            @(negedge clock);
            if (dp_step != 6'(i) || !dp_enable || dp_start) bad++;
        end
        check("mul_run_seq", bad, 0);
        @(negedge clock);
        check("mul_done_enable", longint'(dp_enable), 0);
        check("mul_done_step", longint'(dp_step), 31);
        check("mul_done_busy", longint'(busy), 1);
        @(negedge clock);
        check("mul_idle_busy", longint'(busy), 0);
        check("mul_idle_step", longint'(dp_step), 0);
        check("mul_hold_opA", longint'(dp_operandA), 7);

        // Divide 100 / 7
        issue(0, 1, 32'd100, 32'd7, 1, 0);
        check("div_op", longint'(dp_op), 1);
        check("div_start", longint'(dp_start), 1);
        bad = 0;
        for (int i = 1; i < 33; i++) begin
            @(negedge clock);
            if (dp_step != 6'(i) || !dp_enable) bad++;
        end
        check("div_run_seq", bad, 0);
        @(negedge clock);
        check("div_done_step", longint'(dp_step), 32);
        check("div_done_busy", longint'(busy), 1);
        @(negedge clock);
        check("div_idle_busy", longint'(busy), 0);

        // Divide by zero
        issue(0, 1, 32'd9, 32'd0, 1, 1);
        en_cnt = int'(dp_enable);
        repeat (40) begin
            @(negedge clock);
            en_cnt += int'(dp_enable);
        end
`ifdef MD_SEQ_ZERO_FASTPATH_EN
        check("divzero_enable_cycles", en_cnt, 0);
`else
        check("divzero_enable_cycles", en_cnt, 33);
`endif
        check("divzero_idle", longint'(busy), 0);

        // Multiply aborted by a divide at step 10
        issue(1, 0, 32'd3, 32'd4, 0, 0);
        repeat (9) @(negedge clock);
        check("abort_step9", longint'(dp_step), 9);
        issue(0, 1, 32'd50, 32'd5, 1, 0);
        check("abort_restart_step", longint'(dp_step), 0);
        check("abort_restart_op", longint'(dp_op), 1);
        check("abort_restart_start", longint'(dp_start), 1);
        wait_idle("abort_idle_timeout", 60);

        // Simultaneous requests: multiply wins
        issue(1, 1, 32'd11, 32'd12, 1, 0);
        check("tie_op", longint'(dp_op), 0);
        check("tie_opA", longint'(dp_operandA), 11);
        wait_idle("tie_idle_timeout", 60);

        // Overflow flagged on the last multiply step
        issue(1, 0, 32'hFFFF_FFFF, 32'd2, 1, 1);
        repeat (30) @(negedge clock);
        @(negedge clock);
        check("ovf_step31", longint'(dp_step), 31);
        dp_overflow = 1'b1;
        @(negedge clock);
        dp_overflow = 1'b0;
        wait_idle("ovf_idle_timeout", 10);

        // New request during DONE: finishing op still reports
        issue(1, 0, 32'd5, 32'd5, 1, 0);
        repeat (31) @(negedge clock);
        issue(0, 1, 32'd20, 32'd3, 1, 0);
        check("done_req_busy", longint'(busy), 1);
        check("done_req_start", longint'(dp_start), 1);
        check("done_req_op", longint'(dp_op), 1);
        wait_idle("done_req_idle_timeout", 60);

        // Reset in the middle of a multiply
        issue(1, 0, 32'd8, 32'd8, 0, 0);
        repeat (20) @(negedge clock);
        check("rstmid_step20", longint'(dp_step), 20);
        #2 ctrl_reset_n = 1'b0;
        #1;
        check("rstmid_busy", longint'(busy), 0);
        check("rstmid_enable", longint'(dp_enable), 0);
        check("rstmid_step", longint'(dp_step), 0);
        repeat (2) @(negedge clock);
        ctrl_reset_n = 1'b1;
        repeat (40) @(negedge clock);

        begin
            int k = 0;
            while (sb.size() != 0 && k < 100) begin
                @(negedge clock);
                k++;
            end
        end
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Control FSM for the shared multicycle multiply/divide datapath in the CPU execute stage.
- Accepts ctrl_MULT / ctrl_DIV request pulses and latches the operands.
- Drives the datapath start, step-enable and step-index signals for the programmed iteration count.
- Reports completion via a one-cycle data_resultRDY pulse with data_exception; replaces per-operation free-running cycle counters.

Parameters:
- WIDTH, 32: operand width.
- MULT_CYCLES, 32: datapath iterations for a multiply.
- DIV_CYCLES, 33: datapath iterations for a divide.
- CNT_W, 6: step counter width; MULT_CYCLES and DIV_CYCLES must both be ≤ 2^CNT_W.

Ports:
- clock  in  1  sole clock, rising edge.
- ctrl_reset_n  in  1  asynchronous, active-low reset.
- ctrl_MULT  in  1  multiply request, sampled each edge.
- ctrl_DIV  in  1  divide request, sampled each edge.
- data_operandA  in  WIDTH  operand A, valid with request.
- data_operandB  in  WIDTH  operand B, valid with request.
- dp_operandA  out  WIDTH  latched operand A to datapath.
- dp_operandB  out  WIDTH  latched operand B to datapath.
- dp_op  out  1  0 = multiply, 1 = divide; latched.
- dp_start  out  1  one-cycle load pulse to datapath.
- dp_enable  out  1  datapath iteration enable.
- dp_step  out  CNT_W  current iteration index.
- dp_overflow  in  1  multiply overflow flag from datapath.
- data_resultRDY  out  1  one-cycle completion pulse.
- data_exception  out  1  exception flag, valid while data_resultRDY=1.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (ctrl_reset_n=0, async): state IDLE. All outputs, latched operands, dp_op and dp_step are 0.
- States: IDLE, RUN, DONE. N = MULT_CYCLES if dp_op=0, else DIV_CYCLES.
- Request accept: a request sampled high at edge t, in any state, takes effect at that edge:
  - latch operands and op;
  - dp_step <= 0; state <= RUN.
- Simultaneous ctrl_MULT and ctrl_DIV: multiply wins; the divide is dropped.
- RUN:
  - dp_enable=1.
  - dp_start=1 only when dp_step=0 and the cycle directly follows acceptance.
  - dp_step increments each cycle.
  - At dp_step=N-1 with no new request, next state is DONE.
- DONE (one cycle): data_resultRDY=1 and data_exception driven; next state is IDLE.
- Latency: request at edge t, first RUN cycle t+1, RDY asserted in cycle t+N+1.
- Request during RUN: aborts the current op; no RDY is issued for it; restarts at step 0 with new operands.
- Request during DONE: RDY is still pulsed for the finishing op; the new op enters RUN next cycle.
- data_exception:
  - divide: set when the latched operand B = 0;
  - multiply: dp_overflow registered during the dp_step=N-1 cycle.
  - Cleared whenever data_resultRDY=0.
- dp_operandA/B, dp_op: hold their values from acceptance until the next acceptance; not cleared on completion.
- dp_enable, dp_start: 0 in IDLE and DONE.
- dp_step: holds its final value in DONE; reset to 0 on entering IDLE.
- Reset asserted mid-operation: immediate return to IDLE; no RDY.

Optional Feature:
- MD_SEQ_ZERO_FASTPATH_EN:
  - Defined: a divide accepted with data_operandB=0 skips RUN and goes directly to DONE at the next edge. dp_start and dp_enable are never asserted; RDY is asserted at cycle t+1 with data_exception=1.
  - Undefined: a divide by zero runs the full DIV_CYCLES, then flags data_exception=1 in DONE.
  - Multiply behaviour is identical in both builds.

Test Plan:
- Multiply, A=7, B=6, pulse ctrl_MULT at edge 0 → dp_start=1 in cycle 1; dp_enable high cycles 1–32; data_resultRDY=1 only in cycle 33, data_exception=0.
- Divide, A=100, B=7 → dp_op=1; dp_step runs 0..32; RDY in cycle 34 only; busy low from cycle 35.
- Divide, B=0 → without macro: RDY in cycle 34 with data_exception=1. With MD_SEQ_ZERO_FASTPATH_EN: RDY in cycle 1 with data_exception=1, dp_enable never high.
- ctrl_DIV re-pulsed at dp_step=10 of a multiply → no RDY for the multiply; dp_step returns to 0, dp_op=1; RDY 34 cycles after the second pulse.
- ctrl_MULT and ctrl_DIV high on the same edge → dp_op=0, RDY after 33 cycles. Separately, dp_overflow=1 at step 31 → data_exception=1 with RDY.
- Drop ctrl_reset_n at dp_step=20 → busy, dp_enable and dp_step are 0 immediately (before the next edge); no RDY is ever issued for that op.
